multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (IFU/GRF/ALU/DM/EXT + muxes) reusing one memory port.
//  FSM steps each instruction through IF/ID/EX/MEM/WB, driving per-state enables and mux selects.

---
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: IF/ID/EX/MEM/WB control over one shared memory port.
// Build option ILLEGAL_TRAP_EN: unsupported instructions park the FSM in HALT.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_re,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       npc_sel,
   output logic             reg_we,
   output logic [1:0]       RegDst,
   output logic             ALUSrc,
   output logic [3:0]       ALUCtrl,
   output logic [1:0]       extsel,
   output logic [1:0]       toReg,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t cur;
   state_t nxt;
   logic   retire;

   logic is_r;
   logic is_addu;
   logic is_subu;
   logic is_jr;
   logic is_ori;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_lui;
   logic is_j;
   logic is_jal;
   logic is_exec;

   assign is_r    = (op == 6'h00);
   assign is_addu = is_r && (func == 6'h21);
   assign is_subu = is_r && (func == 6'h23);
   assign is_jr   = is_r && (func == 6'h08);
   assign is_ori  = (op == 6'h0d);
   assign is_lw   = (op == 6'h23);
   assign is_sw   = (op == 6'h2b);
   assign is_beq  = (op == 6'h04);
   assign is_lui  = (op == 6'h0f);
   assign is_j    = (op == 6'h02);
   assign is_jal  = (op == 6'h03);
   assign is_exec = is_addu | is_subu | is_ori | is_lui
                  | is_lw | is_sw | is_beq;

   assign state = cur;

   always_comb begin
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      npc_sel = 2'd0;
      reg_we  = 1'b0;
      RegDst  = 2'd0;
      ALUSrc  = 1'b0;
      ALUCtrl = 4'd0;
      extsel  = 2'd0;
      toReg   = 2'd0;
      retire  = 1'b0;
      nxt     = S_IF;

      // ALU/EXT selects stay put from EX to WB so the datapath result is stable
      if (cur inside {S_EX, S_MEM, S_WB}) begin
         unique case (1'b1)
            is_subu, is_beq: ALUCtrl = 4'd1;
            is_ori: begin
               ALUSrc  = 1'b1;
               ALUCtrl = 4'd2;
            end
            is_lui: begin
               ALUSrc  = 1'b1;
               ALUCtrl = 4'd3;
               extsel  = 2'd2;
            end
            is_lw, is_sw: begin
               ALUSrc = 1'b1;
               extsel = 2'd1;
            end
            default: ALUCtrl = 4'd0;
         endcase
      end

      case (cur)
         S_IF: begin
            mem_re = 1'b1;
            nxt    = S_IF;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
               nxt   = S_ID;
            end
         end
         S_ID: begin
            if (is_j) begin
               pc_we   = 1'b1;
               npc_sel = 2'd2;
               retire  = 1'b1;
            end else if (is_jr) begin
               pc_we   = 1'b1;
               npc_sel = 2'd3;
               retire  = 1'b1;
            end else if (is_jal) begin
               nxt = S_WB;
            end else if (is_exec) begin
               nxt = S_EX;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               nxt = S_HALT;
`else
               retire = 1'b1;
`endif
            end
         end
         S_EX: begin
            if (is_beq) begin
               pc_we   = zero;
               npc_sel = 2'd1;
               retire  = 1'b1;
            end else if (is_lw || is_sw) begin
               nxt = S_MEM;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            mem_re = is_lw;
            mem_we = is_sw;
            nxt    = S_MEM;
            if (mem_ready) begin
               if (is_sw) begin
                  retire = 1'b1;
                  nxt    = S_IF;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            retire = 1'b1;
            if (is_jal) begin
               RegDst  = 2'd2;
               toReg   = 2'd2;
               pc_we   = 1'b1;
               npc_sel = 2'd2;
            end else if (is_addu || is_subu) begin
               RegDst = 2'd1;
            end else if (is_lw) begin
               toReg = 2'd1;
            end
         end
         S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
            nxt = S_HALT;
`else
            nxt = S_IF;
`endif
         end
         default: nxt = S_IF;
      endcase

      // async reset must silence every strobe and select at once
      if (!reset) begin
         mem_re  = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         npc_sel = 2'd0;
         reg_we  = 1'b0;
         RegDst  = 2'd0;
         ALUSrc  = 1'b0;
         ALUCtrl = 4'd0;
         extsel  = 2'd0;
         toReg   = 2'd0;
         retire  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur        <= S_IF;
         retire_cnt <= '0;
      end else begin
         cur <= nxt;
         if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle vectors of inputs and expected controls.
module tb_multicycle_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  op;
   logic [5:0]  func;
   logic        zero;
   logic        mem_ready;
   logic        mem_re, mem_we, ir_we, pc_we, reg_we, ALUSrc;
   logic [1:0]  npc_sel, RegDst, extsel, toReg;
   logic [3:0]  ALUCtrl;
   logic [2:0]  state;
   logic [31:0] retire_cnt;

   logic        s_mem_re, s_mem_we, s_ir_we, s_pc_we, s_reg_we, s_ALUSrc;
   logic [1:0]  s_npc_sel, s_RegDst, s_extsel, s_toReg;
   logic [3:0]  s_ALUCtrl;
   logic [2:0]  s_state;
   logic [1:0]  s_cnt;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .func(func),
      .zero(zero), .mem_ready(mem_ready),
      .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we),
      .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
      .extsel(extsel), .toReg(toReg), .state(state),
      .retire_cnt(retire_cnt)
   );

   // narrow counter copy exercises wrap-around
   multicycle_ctrl #(.CNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .op(op), .func(func),
      .zero(zero), .mem_ready(mem_ready),
      .mem_re(s_mem_re), .mem_we(s_mem_we), .ir_we(s_ir_we),
      .pc_we(s_pc_we), .npc_sel(s_npc_sel), .reg_we(s_reg_we),
      .RegDst(s_RegDst), .ALUSrc(s_ALUSrc), .ALUCtrl(s_ALUCtrl),
      .extsel(s_extsel), .toReg(s_toReg), .state(s_state),
      .retire_cnt(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        rdy;
      logic [2:0]  st;
      logic [17:0] ctl;
      int          cnt;
   } vec_t;

   localparam logic [5:0] ORI = 6'h0d, LW = 6'h23, SW = 6'h2b;
   localparam logic [5:0] BEQ = 6'h04, LUI = 6'h0f, J = 6'h02;
   localparam logic [5:0] JAL = 6'h03, BAD = 6'h3f;
   localparam logic [5:0] ADDU = 6'h21, SUBU = 6'h23, JR = 6'h08;

   vec_t        tv[$];
   int          ec;
   int          checks;
   int          errors;
   logic [17:0] act;
   logic [17:0] zc, ifr, ifw;

   assign act = {mem_re, mem_we, ir_we, pc_we, npc_sel, reg_we,
                 RegDst, ALUSrc, ALUCtrl, extsel, toReg};

   function automatic logic [17:0] c(
      input logic mre, input logic mwe, input logic irw,
      input logic pcw, input logic [1:0] npc, input logic rw,
      input logic [1:0] rd, input logic as, input logic [3:0] ac,
      input logic [1:0] ex, input logic [1:0] tr);
      return {mre, mwe, irw, pcw, npc, rw, rd, as, ac, ex, tr};
   endfunction

   task automatic v(input logic rst, input logic [5:0] o,
                    input logic [5:0] f, input logic z,
                    input logic rdy, input logic [2:0] st,
                    input logic [17:0] ctl);
      vec_t r;
      r.rst = rst; r.op = o; r.fn = f; r.z = z; r.rdy = rdy;
      r.st = st; r.ctl = ctl; r.cnt = ec;
      tv.push_back(r);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
      zc  = '0;
      ifr = c(1,0,1,1,0,0,0,0,0,0,0);
      ifw = c(1,0,0,0,0,0,0,0,0,0,0);
      ec  = 0;

      v(0, 0, 0, 0, 1, 0, zc);
      // ori: IF ID EX WB
      v(1, ORI, 0, 0, 1, 0, ifr);
      v(1, ORI, 0, 0, 1, 1, zc);
      v(1, ORI, 0, 0, 1, 2, c(0,0,0,0,0,0,0,1,2,0,0));
      v(1, ORI, 0, 0, 1, 4, c(0,0,0,0,0,1,0,1,2,0,0));
      ec++;
      // addu with two fetch stalls
      v(1, 0, ADDU, 0, 0, 0, ifw);
      v(1, 0, ADDU, 0, 0, 0, ifw);
      v(1, 0, ADDU, 0, 1, 0, ifr);
      v(1, 0, ADDU, 0, 1, 1, zc);
      v(1, 0, ADDU, 0, 1, 2, zc);
      v(1, 0, ADDU, 0, 1, 4, c(0,0,0,0,0,1,1,0,0,0,0));
      ec++;
      v(1, 0, SUBU, 0, 1, 0, ifr);
      v(1, 0, SUBU, 0, 1, 1, zc);
      v(1, 0, SUBU, 0, 1, 2, c(0,0,0,0,0,0,0,0,1,0,0));
      v(1, 0, SUBU, 0, 1, 4, c(0,0,0,0,0,1,1,0,1,0,0));
      ec++;
      v(1, LUI, 0, 0, 1, 0, ifr);
      v(1, LUI, 0, 0, 1, 1, zc);
      v(1, LUI, 0, 0, 1, 2, c(0,0,0,0,0,0,0,1,3,2,0));
      v(1, LUI, 0, 0, 1, 4, c(0,0,0,0,0,1,0,1,3,2,0));
      ec++;
      // lw with three MEM wait cycles: 8 cycles total
      v(1, LW, 0, 0, 1, 0, ifr);
      v(1, LW, 0, 0, 1, 1, zc);
      v(1, LW, 0, 0, 1, 2, c(0,0,0,0,0,0,0,1,0,1,0));
      for (int i = 0; i < 3; i++)
         v(1, LW, 0, 0, 0, 3, c(1,0,0,0,0,0,0,1,0,1,0));
      v(1, LW, 0, 0, 1, 3, c(1,0,0,0,0,0,0,1,0,1,0));
      v(1, LW, 0, 0, 1, 4, c(0,0,0,0,0,1,0,1,0,1,1));
      ec++;
      v(1, SW, 0, 0, 1, 0, ifr);
      v(1, SW, 0, 0, 1, 1, zc);
      v(1, SW, 0, 0, 1, 2, c(0,0,0,0,0,0,0,1,0,1,0));
      v(1, SW, 0, 0, 1, 3, c(0,1,0,0,0,0,0,1,0,1,0));
      ec++;
      // beq taken then not taken
      v(1, BEQ, 0, 1, 1, 0, ifr);
      v(1, BEQ, 0, 1, 1, 1, zc);
      v(1, BEQ, 0, 1, 1, 2, c(0,0,0,1,1,0,0,0,1,0,0));
      ec++;
      v(1, BEQ, 0, 0, 1, 0, ifr);
      v(1, BEQ, 0, 0, 1, 1, zc);
      v(1, BEQ, 0, 0, 1, 2, c(0,0,0,0,1,0,0,0,1,0,0));
      ec++;
      v(1, JAL, 0, 0, 1, 0, ifr);
      v(1, JAL, 0, 0, 1, 1, zc);
      v(1, JAL, 0, 0, 1, 4, c(0,0,0,1,2,1,2,0,0,0,2));
      ec++;
      v(1, J, 0, 0, 1, 0, ifr);
      v(1, J, 0, 0, 1, 1, c(0,0,0,1,2,0,0,0,0,0,0));
      ec++;
      v(1, 0, JR, 0, 1, 0, ifr);
      v(1, 0, JR, 0, 1, 1, c(0,0,0,1,3,0,0,0,0,0,0));
      ec++;
      // unsupported opcode
      v(1, BAD, 0, 0, 1, 0, ifr);
      v(1, BAD, 0, 0, 1, 1, zc);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++)
         v(1, BAD, 0, 0, 1, 5, zc);
      ec = 0;
      v(0, BAD, 0, 0, 1, 0, zc);
`else
      ec++;
`endif
      // reset lands while sw waits in MEM
      v(1, SW, 0, 0, 1, 0, ifr);
      v(1, SW, 0, 0, 1, 1, zc);
      v(1, SW, 0, 0, 1, 2, c(0,0,0,0,0,0,0,1,0,1,0));
      v(1, SW, 0, 0, 0, 3, c(0,1,0,0,0,0,0,1,0,1,0));
      ec = 0;
      v(0, SW, 0, 0, 0, 0, zc);
      v(0, SW, 0, 0, 1, 0, zc);
      v(1, ORI, 0, 0, 1, 0, ifr);

      foreach (tv[i]) begin
         @(negedge clk);
         reset     = tv[i].rst;
         op        = tv[i].op;
         func      = tv[i].fn;
         zero      = tv[i].z;
         mem_ready = tv[i].rdy;
         #1;
         checks++;
         if (state !== tv[i].st) begin
            errors++;
            $display("FAIL vec%0d state got %0d want %0d",
                     i, state, tv[i].st);
         end
         checks++;
         if (act !== tv[i].ctl) begin
            errors++;
            $display("FAIL vec%0d ctl got %b want %b",
                     i, act, tv[i].ctl);
         end
         checks++;
         if (retire_cnt !== 32'(tv[i].cnt)) begin
            errors++;
            $display("FAIL vec%0d retire_cnt got %0d want %0d",
                     i, retire_cnt, tv[i].cnt);
         end
         checks++;
         if (s_cnt !== 2'(tv[i].cnt)) begin
            errors++;
            $display("FAIL vec%0d wrap_cnt got %0d want %0d",
                     i, s_cnt, 2'(tv[i].cnt));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
